// File: rtl/multicycle_cu_if.sv
// Control bus between the multicycle control unit (master) and the datapath/memory side (slave).
// Carries the instruction word, memory handshake, all datapath strobes and status flags.
interface multicycle_cu_if #(
  parameter int unsigned CNT_W = 32
) ();
  localparam int unsigned INSTR_W = 32;

  logic [INSTR_W-1:0] instr;
  logic               mem_ready;
  logic               branch_taken;
  logic               imem_req;
  logic               ir_we;
  logic               dmem_req;
  logic               dmem_we;
  logic               pc_we;
  logic [1:0]         pc_src;
  logic               reg_we;
  logic               alu_src;
  logic [3:0]         alu_op;
  logic [1:0]         wb_sel;
  logic [2:0]         state;
  logic [CNT_W-1:0]   instret;
  logic               illegal;
  logic               timeout;
  logic               halt;

  modport master (
    input  instr, mem_ready, branch_taken,
    output imem_req, ir_we, dmem_req, dmem_we, pc_we, pc_src, reg_we,
           alu_src, alu_op, wb_sel, state, instret, illegal, timeout, halt
  );

  modport slave (
    output instr, mem_ready, branch_taken,
    input  imem_req, ir_we, dmem_req, dmem_we, pc_we, pc_src, reg_we,
           alu_src, alu_op, wb_sel, state, instret, illegal, timeout, halt
  );
endinterface

// File: rtl/multicycle_cu.sv
// Multicycle control unit: sequences FETCH/DECODE/EXEC/MEM/WB, drives datapath strobes,
// counts retired instructions and traps on illegal opcodes or a memory watchdog expiry.
module multicycle_cu #(
  parameter int unsigned CNT_W     = 32,
  parameter int unsigned TIMEOUT_W = 8,
  parameter int unsigned TIMEOUT   = 200
) (
  input logic            clk,
  input logic            reset,
  multicycle_cu_if.master bus
);

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_I      = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_SYSTEM = 7'b1110011;

  localparam logic [3:0] ALU_ADD   = 4'd0;
  localparam logic [3:0] ALU_SUB   = 4'd1;
  localparam logic [3:0] ALU_AND   = 4'd2;
  localparam logic [3:0] ALU_OR    = 4'd3;
  localparam logic [3:0] ALU_XOR   = 4'd4;
  localparam logic [3:0] ALU_SLT   = 4'd5;
  localparam logic [3:0] ALU_SLTU  = 4'd6;
  localparam logic [3:0] ALU_SLL   = 4'd7;
  localparam logic [3:0] ALU_SRL   = 4'd8;
  localparam logic [3:0] ALU_SRA   = 4'd9;
  localparam logic [3:0] ALU_PASSB = 4'd10;

  localparam logic [TIMEOUT_W-1:0] WD_LAST = TIMEOUT_W'(TIMEOUT - 1);

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_MEM    = 3'd3,
    S_WB     = 3'd4,
    S_HALT   = 3'd5,
    S_TRAP   = 3'd6
  } state_e;

  state_e               state_q, state_d;
  logic [TIMEOUT_W-1:0] wdog_q, wdog_d;
  logic [CNT_W-1:0]     instret_q, instret_d;
  logic                 illegal_q, illegal_d;
  logic                 timeout_q, timeout_d;

  logic       imem_req_c, ir_we_c, dmem_req_c, dmem_we_c, pc_we_c, reg_we_c, alu_src_c;
  logic [1:0] pc_src_c, wb_sel_c;
  logic [3:0] alu_op_c;
  logic       retire_c, set_illegal_c, set_timeout_c;

  logic [6:0] opcode;
  logic [2:0] funct3;
  logic       alt, rd_nz, wd_last;
  logic       is_r, is_i, is_ld, is_st, is_br, is_jal, is_jalr, is_lui, is_sys, is_legal;
  logic       unused_instr_bits;

  assign opcode  = bus.instr[6:0];
  assign funct3  = bus.instr[14:12];
  assign alt     = bus.instr[30];
  assign rd_nz   = (bus.instr[11:7] != 5'd0);
  assign wd_last = (wdog_q == WD_LAST) && !bus.mem_ready;
  assign unused_instr_bits = ^{bus.instr[31], bus.instr[29:15]};

  assign is_r     = (opcode == OP_R);
  assign is_i     = (opcode == OP_I);
  assign is_ld    = (opcode == OP_LOAD);
  assign is_st    = (opcode == OP_STORE);
  assign is_br    = (opcode == OP_BRANCH);
  assign is_jal   = (opcode == OP_JAL);
  assign is_jalr  = (opcode == OP_JALR);
  assign is_lui   = (opcode == OP_LUI);
  assign is_sys   = (opcode == OP_SYSTEM);
  assign is_legal = is_r | is_i | is_ld | is_st | is_br | is_jal | is_jalr | is_lui | is_sys;

  // instr[30] picks SUB only for R-type; it always picks SRA over SRL.
  function automatic logic [3:0] f3_to_alu(input logic [2:0] f3, input logic sel, input logic r_type);
    logic [3:0] op;
    case (f3)
      3'd0:    op = (sel && r_type) ? ALU_SUB : ALU_ADD;
      3'd1:    op = ALU_SLL;
      3'd2:    op = ALU_SLT;
      3'd3:    op = ALU_SLTU;
      3'd4:    op = ALU_XOR;
      3'd5:    op = sel ? ALU_SRA : ALU_SRL;
      3'd6:    op = ALU_OR;
      default: op = ALU_AND;
    endcase
    return op;
  endfunction

  // Next-state and strobe decode.
  always_comb begin
    state_d       = state_q;
    imem_req_c    = 1'b0;
    ir_we_c       = 1'b0;
    dmem_req_c    = 1'b0;
    dmem_we_c     = 1'b0;
    pc_we_c       = 1'b0;
    pc_src_c      = 2'b00;
    reg_we_c      = 1'b0;
    alu_src_c     = 1'b0;
    alu_op_c      = ALU_ADD;
    wb_sel_c      = 2'b00;
    retire_c      = 1'b0;
    set_illegal_c = 1'b0;
    set_timeout_c = 1'b0;

    case (state_q)
      S_FETCH: begin
        imem_req_c = 1'b1;
        if (bus.mem_ready) begin
          ir_we_c = 1'b1;
          state_d = S_DECODE;
        end else if (wd_last) begin
          state_d       = S_TRAP;
          set_timeout_c = 1'b1;
        end
      end
      S_DECODE: begin
        if (!is_legal) begin
          state_d       = S_TRAP;
          set_illegal_c = 1'b1;
        end else if (is_sys) begin
          state_d = S_HALT;
        end else begin
          state_d = S_EXEC;
        end
      end
      S_EXEC: begin
        alu_src_c = is_i | is_ld | is_st | is_jalr | is_lui;
        if (is_r || is_i) alu_op_c = f3_to_alu(funct3, alt, is_r);
        else if (is_br)   alu_op_c = ALU_SUB;
        else if (is_lui)  alu_op_c = ALU_PASSB;
        else              alu_op_c = ALU_ADD;

        if (is_br) begin
          pc_we_c  = 1'b1;
          pc_src_c = bus.branch_taken ? 2'b01 : 2'b00;
          retire_c = 1'b1;
          state_d  = S_FETCH;
        end else if (is_ld || is_st) begin
          state_d = S_MEM;
        end else begin
          state_d = S_WB;
        end
      end
      S_MEM: begin
        dmem_req_c = 1'b1;
        dmem_we_c  = is_st;
        if (bus.mem_ready) begin
          if (is_st) begin
            pc_we_c  = 1'b1;
            retire_c = 1'b1;
            state_d  = S_FETCH;
          end else begin
            state_d = S_WB;
          end
        end else if (wd_last) begin
          state_d       = S_TRAP;
          set_timeout_c = 1'b1;
        end
      end
      S_WB: begin
        reg_we_c = rd_nz;
        wb_sel_c = is_ld ? 2'b01 : ((is_jal || is_jalr) ? 2'b10 : 2'b00);
        pc_we_c  = 1'b1;
        pc_src_c = is_jal ? 2'b01 : (is_jalr ? 2'b10 : 2'b00);
        retire_c = 1'b1;
        state_d  = S_FETCH;
      end
      default: ;
    endcase
  end

  // Watchdog counts only while stalled in the same FETCH/MEM visit; anything else clears it.
  always_comb begin
    wdog_d = '0;
    if ((state_q == S_FETCH || state_q == S_MEM) && !bus.mem_ready && state_d == state_q)
      wdog_d = wdog_q + TIMEOUT_W'(1);
  end

  assign instret_d = retire_c ? instret_q + CNT_W'(1) : instret_q;
  assign illegal_d = illegal_q | set_illegal_c;
  assign timeout_d = timeout_q | set_timeout_c;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= S_FETCH;
      wdog_q    <= '0;
      instret_q <= '0;
      illegal_q <= 1'b0;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      wdog_q    <= wdog_d;
      instret_q <= instret_d;
      illegal_q <= illegal_d;
      timeout_q <= timeout_d;
    end
  end

  assign bus.imem_req = imem_req_c;
  assign bus.ir_we    = ir_we_c;
  assign bus.dmem_req = dmem_req_c;
  assign bus.dmem_we  = dmem_we_c;
  assign bus.pc_we    = pc_we_c;
  assign bus.pc_src   = pc_src_c;
  assign bus.reg_we   = reg_we_c;
  assign bus.alu_src  = alu_src_c;
  assign bus.alu_op   = alu_op_c;
  assign bus.wb_sel   = wb_sel_c;
  assign bus.state    = state_q;
  assign bus.instret  = instret_q;
  assign bus.illegal  = illegal_q;
  assign bus.timeout  = timeout_q;
  assign bus.halt     = (state_q == S_HALT);

endmodule

// File: tb/tb_multicycle_cu.sv
// Directed bench for multicycle_cu: per-instruction cycle traces are generated from the
// instruction class and wait-state pattern, then checked against the DUT every cycle.
module tb_multicycle_cu;
  localparam int unsigned CNT_W = 32;
  localparam int unsigned TO_W  = 8;
  localparam int          TO    = 16;

  logic clk;
  logic reset;

  multicycle_cu_if #(.CNT_W(CNT_W)) bus ();

  multicycle_cu #(.CNT_W(CNT_W), .TIMEOUT_W(TO_W), .TIMEOUT(TO)) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus.master)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef enum int {C_R, C_I, C_LD, C_ST, C_BR, C_JAL, C_JALR, C_LUI, C_SYS, C_ILL} cls_e;

  typedef struct packed {
    logic [31:0] ins;
    logic        rdy;
    logic        bt;
    logic [2:0]  st;
    logic        imem_req, ir_we, dmem_req, dmem_we, pc_we;
    logic [1:0]  pc_src;
    logic        reg_we, alu_src;
    logic [3:0]  alu_op;
    logic [1:0]  wb_sel;
    logic        halt, illegal, timeout, retire;
  } cyc_t;

  typedef struct {
    logic [31:0] ins;
    int          op;
    logic        src;
    logic        bt;
    int          fw;
    int          mw;
  } vec_t;

  cyc_t        q[$];
  cyc_t        cur;
  logic        chk_en = 1'b0;
  int unsigned m_instret = 0;
  int          checks = 0;
  int          errors = 0;
  int          n_cycles, n_dmem, n_fetch;

  // Hand-computed EXEC expectations: {instr, alu_op, alu_src, branch_taken, fetch waits, mem waits}
  vec_t vecs[21] = '{
    '{32'h402081B3, 1,  1'b0, 1'b0, 1, 0},  // sub
    '{32'h4020D1B3, 9,  1'b0, 1'b0, 0, 0},  // sra
    '{32'h0020A1B3, 5,  1'b0, 1'b0, 2, 0},  // slt
    '{32'h0020B1B3, 6,  1'b0, 1'b0, 0, 0},  // sltu
    '{32'h002091B3, 7,  1'b0, 1'b0, 0, 0},  // sll
    '{32'h0020D1B3, 8,  1'b0, 1'b0, 0, 0},  // srl
    '{32'h0020C1B3, 4,  1'b0, 1'b0, 0, 0},  // xor
    '{32'h0020E1B3, 3,  1'b0, 1'b0, 0, 0},  // or
    '{32'h0020F1B3, 2,  1'b0, 1'b0, 0, 0},  // and
    '{32'h00208033, 0,  1'b0, 1'b0, 0, 0},  // add x0 (no reg write)
    '{32'h40000093, 0,  1'b1, 1'b0, 0, 0},  // addi with imm[10] set
    '{32'h4030D113, 9,  1'b1, 1'b0, 0, 0},  // srai
    '{32'h0030D113, 8,  1'b1, 1'b0, 0, 0},  // srli
    '{32'h0FF0C113, 4,  1'b1, 1'b0, 0, 0},  // xori
    '{32'h4000E113, 3,  1'b1, 1'b0, 0, 0},  // ori with imm[10] set
    '{32'h0020A223, 0,  1'b1, 1'b0, 0, 2},  // sw
    '{32'h0000A283, 0,  1'b1, 1'b0, 1, 0},  // lw
    '{32'h008000EF, 0,  1'b0, 1'b0, 0, 0},  // jal x1
    '{32'h00008067, 0,  1'b1, 1'b0, 0, 0},  // jalr x0
    '{32'h123453B7, 10, 1'b1, 1'b0, 0, 0},  // lui
    '{32'h00208463, 1,  1'b0, 1'b1, 3, 0}   // beq taken after fetch waits
  };

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got 0x%0h, want 0x%0h", name, $time, act, exp);
    end
  endtask

  function automatic cls_e cls_of(input logic [31:0] ins);
    case (ins[6:0])
      7'b0110011: return C_R;
      7'b0010011: return C_I;
      7'b0000011: return C_LD;
      7'b0100011: return C_ST;
      7'b1100011: return C_BR;
      7'b1101111: return C_JAL;
      7'b1100111: return C_JALR;
      7'b0110111: return C_LUI;
      7'b1110011: return C_SYS;
      default:    return C_ILL;
    endcase
  endfunction

  function automatic cyc_t rec(input logic [31:0] ins, input logic bt, input logic [2:0] st, input logic rdy);
    cyc_t r;
    r          = '0;
    r.ins      = ins;
    r.bt       = bt;
    r.st       = st;
    r.rdy      = rdy;
    r.imem_req = (st == 3'd0);
    return r;
  endfunction

  task automatic push_term(input logic [31:0] ins, input logic bt, input logic [2:0] st,
                           input int hold, input logic ill, input logic tmo);
    cyc_t r;
    for (int k = 0; k < hold; k++) begin
      r         = rec(ins, bt, st, k[0]);
      r.halt    = (st == 3'd5);
      r.illegal = ill;
      r.timeout = tmo;
      q.push_back(r);
    end
  endtask

  // Expected cycle trace of one instruction, from its class and the wait-state pattern.
  task automatic build(input logic [31:0] ins, input int op, input logic src, input logic bt,
                       input int fw, input int mw, input int hold);
    cls_e c;
    cyc_t r;
    c = cls_of(ins);
    for (int k = 0; k < fw && k < TO; k++) q.push_back(rec(ins, bt, 3'd0, 1'b0));
    if (fw >= TO) begin
      push_term(ins, bt, 3'd6, hold, 1'b0, 1'b1);
      return;
    end
    r = rec(ins, bt, 3'd0, 1'b1);
    r.ir_we = 1'b1;
    q.push_back(r);
    q.push_back(rec(ins, bt, 3'd1, 1'b1));
    if (c == C_ILL) begin
      push_term(ins, bt, 3'd6, hold, 1'b1, 1'b0);
      return;
    end
    if (c == C_SYS) begin
      push_term(ins, bt, 3'd5, hold, 1'b0, 1'b0);
      return;
    end
    r         = rec(ins, bt, 3'd2, 1'b1);
    r.alu_src = src;
    r.alu_op  = 4'(op);
    if (c == C_BR) begin
      r.pc_we  = 1'b1;
      r.pc_src = bt ? 2'b01 : 2'b00;
      r.retire = 1'b1;
      q.push_back(r);
      return;
    end
    q.push_back(r);
    if (c == C_LD || c == C_ST) begin
      r          = rec(ins, bt, 3'd3, 1'b0);
      r.dmem_req = 1'b1;
      r.dmem_we  = (c == C_ST);
      for (int k = 0; k < mw; k++) q.push_back(r);
      r.rdy = 1'b1;
      if (c == C_ST) begin
        r.pc_we  = 1'b1;
        r.retire = 1'b1;
        q.push_back(r);
        return;
      end
      q.push_back(r);
    end
    r        = rec(ins, bt, 3'd4, 1'b0);
    r.reg_we = (ins[11:7] != 5'd0);
    r.wb_sel = (c == C_LD) ? 2'b01 : ((c == C_JAL || c == C_JALR) ? 2'b10 : 2'b00);
    r.pc_we  = 1'b1;
    r.pc_src = (c == C_JAL) ? 2'b01 : ((c == C_JALR) ? 2'b10 : 2'b00);
    r.retire = 1'b1;
    q.push_back(r);
  endtask

  task automatic run_q();
    n_cycles = 0;
    n_dmem   = 0;
    n_fetch  = 0;
    while (q.size() > 0) begin
      cur              = q.pop_front();
      bus.instr        = cur.ins;
      bus.mem_ready    = cur.rdy;
      bus.branch_taken = cur.bt;
      chk_en           = 1'b1;
      @(negedge clk);
      n_cycles++;
      if (bus.dmem_req === 1'b1) n_dmem++;
      if (bus.state === 3'd0) n_fetch++;
      @(posedge clk);
      if (cur.retire) m_instret++;
      #1;
    end
    chk_en = 1'b0;
  endtask

  task automatic do_reset();
    chk_en        = 1'b0;
    bus.mem_ready = 1'b0;
    reset         = 1'b0;
    #2;
    chk("rst_state",    32'(bus.state), 32'd0);
    chk("rst_imem_req", 32'(bus.imem_req), 32'd1);
    chk("rst_pc_we",    32'(bus.pc_we), 32'd0);
    chk("rst_instret",  bus.instret, 32'd0);
    chk("rst_flags",    32'({bus.illegal, bus.timeout, bus.halt}), 32'd0);
    @(posedge clk);
    @(posedge clk);
    #3 reset = 1'b1;
    m_instret = 0;
  endtask

  // Per-cycle comparison of every DUT output against the current expected record.
  always @(negedge clk) begin
    if (chk_en) begin
      chk("state",    32'(bus.state),    32'(cur.st));
      chk("imem_req", 32'(bus.imem_req), 32'(cur.imem_req));
      chk("ir_we",    32'(bus.ir_we),    32'(cur.ir_we));
      chk("dmem_req", 32'(bus.dmem_req), 32'(cur.dmem_req));
      chk("dmem_we",  32'(bus.dmem_we),  32'(cur.dmem_we));
      chk("pc_we",    32'(bus.pc_we),    32'(cur.pc_we));
      chk("pc_src",   32'(bus.pc_src),   32'(cur.pc_src));
      chk("reg_we",   32'(bus.reg_we),   32'(cur.reg_we));
      chk("alu_src",  32'(bus.alu_src),  32'(cur.alu_src));
      chk("alu_op",   32'(bus.alu_op),   32'(cur.alu_op));
      chk("wb_sel",   32'(bus.wb_sel),   32'(cur.wb_sel));
      chk("instret",  bus.instret,       m_instret);
      chk("illegal",  32'(bus.illegal),  32'(cur.illegal));
      chk("timeout",  32'(bus.timeout),  32'(cur.timeout));
      chk("halt",     32'(bus.halt),     32'(cur.halt));
    end
  end

  initial begin
    reset            = 1'b1;
    bus.instr        = '0;
    bus.mem_ready    = 1'b0;
    bus.branch_taken = 1'b0;
    #1 do_reset();

    build(32'h002081B3, 0, 1'b0, 1'b0, 0, 0, 0);
    run_q();
    chk("add_cycles",  32'(n_cycles), 32'd4);
    chk("add_instret", bus.instret, 32'd1);

    build(32'h0000A283, 0, 1'b1, 1'b0, 0, 3, 0);
    run_q();
    chk("lw_cycles",   32'(n_cycles), 32'd8);
    chk("lw_dmem_req", 32'(n_dmem), 32'd4);

    build(32'h00208463, 1, 1'b0, 1'b1, 0, 0, 0);
    run_q();
    chk("beq_t_cycles", 32'(n_cycles), 32'd3);
    build(32'h00208463, 1, 1'b0, 1'b0, 0, 0, 0);
    run_q();
    chk("beq_nt_cycles", 32'(n_cycles), 32'd3);
    chk("instret_4", bus.instret, 32'd4);

    foreach (vecs[i]) begin
      build(vecs[i].ins, vecs[i].op, vecs[i].src, vecs[i].bt, vecs[i].fw, vecs[i].mw, 0);
      run_q();
    end
    chk("instret_25", bus.instret, 32'd25);

    build(32'h00000000, 0, 1'b0, 1'b0, 0, 0, 20);
    run_q();
    chk("ill_flag", 32'(bus.illegal), 32'd1);
    do_reset();

    build(32'h002081B3, 0, 1'b0, 1'b0, 0, 0, 0);
    build(32'h00000073, 0, 1'b0, 1'b0, 0, 0, 10);
    run_q();
    chk("halt_flag",    32'(bus.halt), 32'd1);
    chk("halt_instret", bus.instret, 32'd1);
    do_reset();

    build(32'h002081B3, 0, 1'b0, 1'b0, TO, 0, 5);
    run_q();
    chk("wd_fetch_cycles", 32'(n_fetch), 32'd16);
    chk("wd_timeout",      32'(bus.timeout), 32'd1);
    do_reset();

    build(32'h002081B3, 0, 1'b0, 1'b0, TO - 1, 0, 0);
    run_q();
    chk("wd_edge_cycles", 32'(n_cycles), 32'd19);

    for (int k = 0; k < 10; k++) q.push_back(rec(32'h002081B3, 1'b0, 3'd0, 1'b0));
    run_q();
    do_reset();
    build(32'h002081B3, 0, 1'b0, 1'b0, TO - 1, 0, 0);
    run_q();
    chk("wd_rst_cycles",  32'(n_cycles), 32'd19);
    chk("wd_rst_instret", bus.instret, 32'd1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/multicycle_cu.md
# multicycle_cu

Parametrised multicycle control unit for the processor core. It replaces single-cycle decode with a state machine that sequences FETCH, DECODE, EXEC, MEM and WB. Every memory access uses a request/ready handshake, guarded by a watchdog. The block drives all datapath strobes (PC, IR, register file, ALU, memory, writeback mux), counts retired instructions, and reports illegal-opcode, halt and timeout conditions.

## Interface

Parameters:
- CNT_W, 32, width of the retired-instruction counter
- TIMEOUT_W, 8, width of the memory-wait watchdog counter
- TIMEOUT, 200, maximum wait cycles for mem_ready before trapping; must satisfy 1 ≤ TIMEOUT < 2^TIMEOUT_W

Ports:
- clk  in  1  single clock; all state updates on rising edge
- reset  in  1  asynchronous, active-low (0 = reset asserted)
- instr  in  32  current instruction from the datapath IR; valid from DECODE onward
- mem_ready  in  1  memory completes the current imem_req/dmem_req this cycle
- branch_taken  in  1  datapath comparator result for the current branch
- imem_req  out  1  instruction fetch request
- ir_we  out  1  latch the fetched word into IR
- dmem_req  out  1  data memory request
- dmem_we  out  1  data memory write (store)
- pc_we  out  1  PC update
- pc_src  out  2  00 = pc+4, 01 = branch/JAL target, 10 = JALR target
- reg_we  out  1  register file write
- alu_src  out  1  0 = rs2, 1 = immediate
- alu_op  out  4  0 ADD, 1 SUB, 2 AND, 3 OR, 4 XOR, 5 SLT, 6 SLTU, 7 SLL, 8 SRL, 9 SRA, 10 PASSB
- wb_sel  out  2  00 = ALU, 01 = memory, 10 = pc+4
- state  out  3  current state (debug)
- instret  out  CNT_W  retired-instruction count
- illegal  out  1  sticky: illegal opcode decoded
- timeout  out  1  sticky: watchdog expired
- halt  out  1  high while in HALT

## Operation

- States: FETCH = 0, DECODE = 1, EXEC = 2, MEM = 3, WB = 4, HALT = 5, TRAP = 6.
- Strobes are combinational from state and instr. Any strobe not listed for a state is 0.
- Supported opcodes: R 0110011, I-ALU 0010011, LOAD 0000011, STORE 0100011, BRANCH 1100011, JAL 1101111, JALR 1100111, LUI 0110111, SYSTEM 1110011. Every other opcode is illegal.
- FETCH:
  - imem_req = 1.
  - On mem_ready: ir_we = 1, next state DECODE.
  - Otherwise the watchdog increments.
- DECODE:
  - Illegal opcode: next state TRAP, set illegal.
  - SYSTEM: next state HALT.
  - All other opcodes: next state EXEC.
- EXEC:
  - alu_src = 1 for I-ALU, LOAD, STORE, JALR and LUI.
  - alu_op decoding:
    - R type: from funct3, with instr[30] selecting SUB or SRA.
    - I-ALU: from funct3, with instr[30] used only for SRAI.
    - LOAD, STORE, JALR: ADD.
    - BRANCH: SUB.
    - LUI: PASSB.
  - R, I-ALU, LUI, JAL, JALR: next state WB.
  - LOAD, STORE: next state MEM.
  - BRANCH: pc_we = 1, pc_src = 01 if branch_taken else 00; retire; next state FETCH.
- MEM:
  - dmem_req = 1; dmem_we = 1 for STORE.
  - Wait for mem_ready (watchdog active).
  - STORE: pc_we = 1, pc_src = 00, retire, next state FETCH.
  - LOAD: next state WB.
- WB:
  - reg_we = 1 unless instr[11:7] == 0.
  - wb_sel: 01 for LOAD, 10 for JAL/JALR, otherwise 00.
  - pc_we = 1; pc_src = 01 for JAL, 10 for JALR, otherwise 00.
  - Retire; next state FETCH.
- HALT and TRAP: all strobes 0; the state is held until reset.
- Retire means instret increments by 1 in that cycle. instret wraps modulo 2^CNT_W.
- Watchdog:
  - Cleared on entry to FETCH or MEM, and on mem_ready.
  - Increments each cycle the block is in FETCH or MEM without mem_ready.
  - If the counter equals TIMEOUT−1 and mem_ready is still 0, next state TRAP and timeout is set.
  - mem_ready arriving in that same cycle wins: normal transition, no trap.

## Timing

- While reset = 0, asynchronously: state = FETCH, instret = 0, watchdog = 0, illegal = timeout = halt = 0.
  - All strobes are 0 except imem_req = 1, which is decoded from FETCH.
  - An in-flight request is abandoned; the memory side must tolerate this.
- Latency with zero wait states:
  - branch: 3 cycles
  - R / I-ALU / LUI / JAL / JALR / store: 4 cycles
  - load: 5 cycles
  - Each cycle mem_ready is low in FETCH or MEM adds 1 cycle.
- Handshake: a request is held high continuously until the cycle mem_ready = 1. The transfer completes in that cycle. mem_ready is ignored outside FETCH and MEM.
- instret updates on the clock edge that ends the retiring cycle.
- Sticky flags assert on the edge entering TRAP.

## Test plan

- Reset: hold reset = 0, toggle clk, deassert mid-cycle → state = 0, imem_req = 1, instret = 0, all flags 0.
- Add: instr = 0x002081B3 (add x3,x1,x2), mem_ready = 1 → FETCH, DECODE, EXEC, WB in 4 cycles.
  - EXEC: alu_op = 0, alu_src = 0.
  - WB: reg_we = 1, wb_sel = 00, pc_we = 1, pc_src = 00.
  - instret = 1.
- Load with wait states: instr = 0x0000A283 (lw x5,0(x1)), mem_ready low for 3 cycles in MEM → dmem_req high for 4 cycles, dmem_we = 0, total 8 cycles, WB wb_sel = 01.
- Branch: instr = 0x00208463 (beq).
  - branch_taken = 1 → EXEC pc_we = 1, pc_src = 01, back in FETCH after 3 cycles.
  - Repeat with branch_taken = 0 → pc_src = 00.
- Illegal and halt:
  - instr = 0x00000000 → TRAP, illegal = 1, strobes 0 for 20 cycles.
  - After reset, instr = 0x00000073 → HALT, halt = 1, instret unchanged.
- Watchdog: TIMEOUT = 16, mem_ready stuck 0 in FETCH → TRAP and timeout = 1 after exactly 16 wait cycles.
  - mem_ready on the 16th cycle → DECODE, no trap.
  - reset pulled low during the wait → immediate return to FETCH with the counter cleared.
